aes_iter_cipher: RTL and testbench
==================================

Name: aes_iter_cipher

Overview:
- Iterative, parametrised AES encryption core for AES-128, AES-192 and AES-256.
- One cipher round per clock, with the key schedule expanded one word per clock and cached for reuse across blocks.
- Valid/ready handshakes on input and output.
- Successor to the fully unrolled combinational cipher; reuses the existing SubBytes, ShiftRows, MixColumns and AddRoundKey round primitives, trading area for multi-cycle latency.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8 (elaboration error otherwise).
- NR, NK+6, number of rounds (derived; never overridden).
- NW, 4*(NR+1), total expanded key words (44/52/60).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext/key offer.
- in_ready  out  1  core can accept a block.
- in_data  in  128  plaintext, byte 0 in [127:120].
- in_key  in  NK*32  cipher key, word 0 in MSBs.
- in_key_new  in  1  1 = expand in_key; 0 = reuse cached schedule.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext.
- busy  out  1  high in KEXP or ROUND.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, key_ok=0, round counter=0, word counter=0.
- FSM states: IDLE, KEXP, ROUND, DONE.
- IDLE: in_ready=1.
  - Accept on in_valid&&in_ready: capture in_data into the state register.
  - If in_key_new=1 or key_ok=0: load in_key into w[0..NK-1], set wi=NK, go to KEXP.
  - Otherwise go to ROUND with r=0.
  - in_key is ignored when the cached schedule is used.
- KEXP: one word per cycle, wi from NK to NW-1, using temp=w[wi-1].
  - If wi mod NK==0: temp = SubWord(RotWord(temp)) ^ Rcon[wi/NK-1].
  - Else if NK==8 and wi mod 8==4: temp = SubWord(temp).
  - w[wi] = w[wi-NK] ^ temp.
  - Rcon table holds 01,02,04,08,10,20,40,80,1B,36 in the top byte.
  - After wi=NW-1: key_ok=1, go to ROUND with r=0.
  - Duration is NW-NK cycles: 40, 46 or 52.
- ROUND: one cycle per r, r = 0..NR.
  - r=0: state ^= w[0..3].
  - 1<=r<NR: state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), w[4r..4r+3]).
  - r=NR: same, MixColumns omitted. Then go to DONE.
- DONE: out_valid=1, out_data=state.
  - out_data and out_valid stay stable until out_ready=1.
  - On that cycle, go to IDLE with out_valid=0.
  - Next accept possible the following cycle; no input/output overlap.
- Latency, accept cycle T:
  - New key: out_valid first high at T+(NW-NK)+NR+2 (AES-128: T+52).
  - Cached key: T+NR+2 (AES-128: T+12).
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0.
- in_valid while not IDLE is ignored; the block is not captured.
- Reset mid-operation: everything returns to reset values, including key_ok=0, so the next block is forced to expand its key.
- Key cache:
  - w[] persists across blocks.
  - Only a completed expansion sets key_ok.
  - An interrupted expansion leaves key_ok=0.
- S-box usage: 16 instances in the state datapath plus 4 for SubWord; not shared between them.

Decomposition:
- Shared package aes_pkg holds:
  - S-box table function.
  - Rcon function.
  - xtime function.
  - FSM state enum.
  - Legal-NK check.
- Existing SubBytes, ShiftRows, MixColumns and AddRoundKey are instantiated once each.
- One new sub-module: aes_key_word_gen, combinational next-word computation from w[wi-1], w[wi-NK], wi and NK.
- The FSM, counters and word store stay in the top module.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, in_key_new=1 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 52 cycles after accept.
- NK=4, second block pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, in_key_new=1; then repeat the same pt with in_key_new=0 and in_key=0 -> 69c4e0d86a7b0430d8cdb78070b4c55a both times; second result arrives 12 cycles after accept.
- NK=6, key 000102...1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 46+12+2=60 cycles.
- NK=8, key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, latency 52+14+2=68 cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored; release -> one transfer, in_ready=1 the next cycle.
- Assert rst_n=0 mid-KEXP, then submit with in_key_new=0 -> expansion still performed (key_ok cleared), correct FIPS-197 ciphertext, full new-key latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box, Rcon, GF(2^8) doubling, FSM states and NK legality.
package aes_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_ROUND, ST_DONE} aes_state_e;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   // Byte 0 of the table sits in the MSBs.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic bit nk_legal(input int unsigned nk);
      return (nk == 4) || (nk == 6) || (nk == 8);
   endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational key-schedule step: w[wi] from w[wi-1], w[wi-NK] and wi.
module aes_key_word_gen
   import aes_pkg::*;
#(
   parameter int unsigned NK = 4
) (
   input  logic [31:0] w_prev_i,
   input  logic [31:0] w_back_i,
   input  logic [5:0]  wi_i,
   output logic [31:0] w_o
);
   logic [5:0]  wi_mod;
   logic [3:0]  rc_idx;
   logic [31:0] sw_in, sw_out, temp;

   assign wi_mod = wi_i % 6'(NK);
   assign rc_idx = 4'(wi_i / 6'(NK) - 6'd1);
   // One SubWord serves both the rotated and the NK=8 mid-block cases.
   assign sw_in  = (wi_mod == '0) ? {w_prev_i[23:0], w_prev_i[31:24]} : w_prev_i;

   always_comb begin
      sw_out = '0;
      for (int unsigned b = 0; b < 4; b++)
         sw_out[8*b +: 8] = sbox(sw_in[8*b +: 8]);
   end

   always_comb begin
      temp = w_prev_i;
      if (wi_mod == '0)
         temp = sw_out ^ {rcon(rc_idx), 24'h000000};
      else if (NK == 8 && wi_mod == 6'd4)
         temp = sw_out;
   end

   assign w_o = w_back_i ^ temp;
endmodule

// File: rtl/aes_round_prims.sv
// AES round primitives on a 128-bit state, byte 0 in [127:120], column-major.
module aes_sub_bytes
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   output logic [127:0] state_o
);
   always_comb begin
      state_o = '0;
      for (int unsigned b = 0; b < 16; b++)
         state_o[8*b +: 8] = sbox(state_i[8*b +: 8]);
   end
endmodule

module aes_shift_rows (
   input  logic [127:0] state_i,
   output logic [127:0] state_o
);
   // Row r of column c takes the byte from column (c+r) mod 4.
   always_comb begin
      state_o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            state_o[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c+r)%4)+r) -: 8];
   end
endmodule

module aes_mix_columns
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   output logic [127:0] state_o
);
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   always_comb begin
      state_o = '0;
      for (int unsigned c = 0; c < 4; c++)
         state_o[127-32*c -: 32] = mix_col(state_i[127-32*c -: 32]);
   end
endmodule

module aes_add_round_key (
   input  logic [127:0] state_i,
   input  logic [127:0] key_i,
   output logic [127:0] state_o
);
   assign state_o = state_i ^ key_i;
endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption core: one round per clock, cached one-word-per-clock key schedule.
module aes_iter_cipher
   import aes_pkg::*;
#(
   parameter  int unsigned NK = 4,
   localparam int unsigned NR = NK + 6,
   localparam int unsigned NW = 4 * (NR + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   input  logic [NK*32-1:0]  in_key,
   input  logic              in_key_new,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_data,
   output logic              busy
);
   if (!nk_legal(NK)) begin : g_bad_nk
      $error("aes_iter_cipher: NK must be 4, 6 or 8");
   end

   aes_state_e   state_q, state_d;
   logic [3:0]   r_q, r_d;
   logic [5:0]   wi_q, wi_d;
   logic         key_ok_q, key_ok_d;
   logic [127:0] blk_q, blk_d;
   logic [31:0]  w_q [NW];

   logic         accept, load_key;
   logic [5:0]   rk_base;
   logic [31:0]  w_new;
   logic [127:0] rk, sb, sr, mc, ark_in, ark_out;

   assign accept   = in_valid && (state_q == ST_IDLE);
   assign load_key = accept && (in_key_new || !key_ok_q);
   assign rk_base  = {r_q, 2'b00};
   assign rk       = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};

   aes_key_word_gen #(.NK(NK)) u_kgen (
      .w_prev_i (w_q[wi_q - 6'd1]),
      .w_back_i (w_q[wi_q - 6'(NK)]),
      .wi_i     (wi_q),
      .w_o      (w_new)
   );

   aes_sub_bytes     u_sb  (.state_i(blk_q), .state_o(sb));
   aes_shift_rows    u_sr  (.state_i(sb),    .state_o(sr));
   aes_mix_columns   u_mc  (.state_i(sr),    .state_o(mc));

   // Round 0 is a bare key whitening; the last round bypasses MixColumns.
   assign ark_in = (r_q == '0) ? blk_q : ((r_q == 4'(NR)) ? sr : mc);

   aes_add_round_key u_ark (.state_i(ark_in), .key_i(rk), .state_o(ark_out));

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      wi_d     = wi_q;
      key_ok_d = key_ok_q;
      blk_d    = blk_q;
      case (state_q)
         ST_IDLE: if (in_valid) begin
            blk_d = in_data;
            r_d   = '0;
            if (in_key_new || !key_ok_q) begin
               key_ok_d = 1'b0;
               wi_d     = 6'(NK);
               state_d  = ST_KEXP;
            end else begin
               state_d = ST_ROUND;
            end
         end
         ST_KEXP: if (wi_q == 6'(NW - 1)) begin
            key_ok_d = 1'b1;
            r_d      = '0;
            state_d  = ST_ROUND;
         end else begin
            wi_d = wi_q + 6'd1;
         end
         ST_ROUND: begin
            blk_d = ark_out;
            if (r_q == 4'(NR)) state_d = ST_DONE;
            else               r_d     = r_q + 4'd1;
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         r_q      <= '0;
         wi_q     <= '0;
         key_ok_q <= 1'b0;
         blk_q    <= '0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         wi_q     <= wi_d;
         key_ok_q <= key_ok_d;
         blk_q    <= blk_d;
      end
   end

   // The schedule store is deliberately not reset; key_ok_q guards its validity.
   always_ff @(posedge clk) begin
      if (load_key) begin
         for (int unsigned i = 0; i < NK; i++)
            w_q[i] <= in_key[(NK-1-i)*32 +: 32];
      end else if (state_q == ST_KEXP) begin
         w_q[wi_q] <= w_new;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_KEXP) || (state_q == ST_ROUND);
   assign out_data  = out_valid ? blk_q : '0;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: three instances (NK=4/6/8) against a textbook AES model.
module tb_aes_iter_cipher;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid_s   [3];
   logic         in_ready_s   [3];
   logic [127:0] in_data_s    [3];
   logic [255:0] in_key_s     [3];
   logic         in_key_new_s [3];
   logic         out_valid_s  [3];
   logic         out_ready_s  [3];
   logic [127:0] out_data_s   [3];
   logic         busy_s       [3];

   int checks = 0;
   int failures = 0;

   logic [7:0]   sbt [256];
   logic [255:0] cache_key [3];
   bit           cache_ok  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned NKG = 4 + 2 * g;
      aes_iter_cipher #(.NK(NKG)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid_s[g]),
         .in_ready   (in_ready_s[g]),
         .in_data    (in_data_s[g]),
         .in_key     (in_key_s[g][NKG*32-1:0]),
         .in_key_new (in_key_new_s[g]),
         .out_valid  (out_valid_s[g]),
         .out_ready  (out_ready_s[g]),
         .out_data   (out_data_s[g]),
         .busy       (busy_s[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box derived from the multiplicative inverse and the affine map.
   task automatic build_sbox();
      logic [7:0] inv, rot, acc;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         rot = inv;
         acc = inv;
         for (int k = 0; k < 4; k++) begin
            rot = {rot[6:0], rot[7]};
            acc = acc ^ rot;
         end
         sbt[x] = acc ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
   endfunction

   function automatic logic [127:0] aes_ref(input int nk, input logic [127:0] pt, input logic [255:0] key);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc = 8'h01;
      logic [127:0] res;
      int           nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[(nk-1-i)*32 +: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[4*c+r] = sbt[s[4*((c+r)%4)+r]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (rnd < nr)
                  s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                           ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
               else
                  s[4*c+r] = t[4*c+r];
         for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
      end
      for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
      return res;
   endfunction

   // ---------------- checkers ----------------
   task automatic check128(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic checkint(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic run_block(input int g, input logic [127:0] p, input logic [255:0] k,
                            input bit knew, input int hold, input string tag,
                            output logic [127:0] got);
      int           nk, lat, explat;
      logic [127:0] exp;
      nk = 4 + 2 * g;
      if (knew || !cache_ok[g]) begin
         cache_key[g] = k;
         cache_ok[g]  = 1'b1;
         explat = (4*(nk+7) - nk) + (nk + 6) + 2;
      end else begin
         explat = nk + 8;
      end
      exp = aes_ref(nk, p, cache_key[g]);
      @(negedge clk);
      check1({tag, " in_ready idle"}, in_ready_s[g], 1'b1);
      in_valid_s[g]   = 1'b1;
      in_data_s[g]    = p;
      in_key_s[g]     = k;
      in_key_new_s[g] = knew;
      @(posedge clk); #1;
      in_valid_s[g] = 1'b0;
      check1({tag, " busy"}, busy_s[g], 1'b1);
      lat = 1;
      while (!out_valid_s[g] && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      check1({tag, " out_valid"}, out_valid_s[g], 1'b1);
      checkint({tag, " latency"}, lat, explat);
      check128({tag, " data"}, out_data_s[g], exp);
      got = out_data_s[g];
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check128({tag, " hold data"}, out_data_s[g], exp);
         check1({tag, " hold in_ready"}, in_ready_s[g], 1'b0);
         in_valid_s[g]   = h[0];
         in_data_s[g]    = ~p;
         in_key_new_s[g] = 1'b1;
      end
      @(negedge clk);
      in_valid_s[g]  = 1'b0;
      out_ready_s[g] = 1'b1;
      @(posedge clk); #1;
      out_ready_s[g] = 1'b0;
      check1({tag, " out_valid drop"}, out_valid_s[g], 1'b0);
      check1({tag, " in_ready back"}, in_ready_s[g], 1'b1);
      @(posedge clk); #1;
      check1({tag, " no phantom"}, busy_s[g], 1'b0);
   endtask

   // ---------------- directed + random sequence ----------------
   localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K4  = 256'h000102030405060708090a0b0c0d0e0f;

   initial begin
      logic [127:0] got;
      logic [255:0] rk;
      for (int g = 0; g < 3; g++) begin
         in_valid_s[g] = 1'b0;  in_data_s[g] = '0;  in_key_s[g] = '0;
         in_key_new_s[g] = 1'b0; out_ready_s[g] = 1'b0; cache_ok[g] = 1'b0;
      end
      build_sbox();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < 3; g++) begin
         check1("rst in_ready", in_ready_s[g], 1'b1);
         check1("rst out_valid", out_valid_s[g], 1'b0);
         check1("rst busy", busy_s[g], 1'b0);
         check128("rst out_data", out_data_s[g], '0);
      end

      run_block(0, 128'h3243f6a8885a308d313198a2e0370734,
                256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 0, "fips_c1", got);
      check128("fips_c1 kat", got, 128'h3925841d02dc09fbdc118597196a0b32);

      run_block(0, PT2, K4, 1'b1, 0, "aes128_new", got);
      check128("aes128_new kat", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      run_block(0, PT2, '0, 1'b0, 0, "aes128_cached", got);
      check128("aes128_cached kat", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      run_block(1, PT2, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 1'b1, 0, "aes192", got);
      check128("aes192 kat", got, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      run_block(2, PT2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                1'b1, 0, "aes256", got);
      check128("aes256 kat", got, 128'h8ea2b7ca516745bfeafc49904b496089);

      run_block(0, PT2, '0, 1'b0, 20, "backpressure", got);

      // Reset in the middle of a key expansion.
      @(negedge clk);
      in_valid_s[0] = 1'b1; in_data_s[0] = PT2; in_key_s[0] = K4; in_key_new_s[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_s[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check1("midkexp busy", busy_s[0], 1'b1);
      rst_n = 1'b0;
      #2;
      check1("async rst busy", busy_s[0], 1'b0);
      check1("async rst in_ready", in_ready_s[0], 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < 3; g++) cache_ok[g] = 1'b0;
      run_block(0, PT2, K4, 1'b0, 0, "post_rst", got);
      check128("post_rst kat", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      for (int n = 0; n < 12; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run_block(int'($urandom_range(0, 2)), {$urandom, $urandom, $urandom, $urandom}, rk,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random", got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
